interrupt_controller: RTL and testbench



---
 rtl/gb_defs_pkg.sv | 23 ++
 rtl/interrupt_controller_prio_enc.sv | 26 ++
 rtl/interrupt_controller.sv | 128 ++++++++++++
 tb/tb_interrupt_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gb_defs_pkg.sv
// Shared Game Boy definitions used by the interrupt controller.
// Interrupt source indices (bit 0 = highest priority), the two bus
// addresses of the interrupt registers, the base dispatch vector and
// the dispatch FSM state type.
package gb_defs;

  localparam int INT_VBLANK = 0;
  localparam int INT_STAT   = 1;
  localparam int INT_TIMER  = 2;
  localparam int INT_SERIAL = 3;
  localparam int INT_JOYPAD = 4;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  localparam logic [7:0] VECTOR_BASE = 8'h40;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } int_state_e;

endpackage

// File: rtl/interrupt_controller_prio_enc.sv
// int_prio_enc: combinational lowest-index-first priority encoder.
// Ports:
//   req   in  N  qualified request vector (IF & IE)
//   found out 1  at least one bit of req is set
//   idx   out 3  index of the lowest set bit (0 when none)
module int_prio_enc #(
  parameter int N = 5
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [2:0]   idx
);

  // Scan from the top down so the lowest set index is written last.
  always_comb begin
    found = 1'b0;
    idx   = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: IF/IE register pair plus dispatch handshake.
// Rising edges of int_req set IF bits; IF & IE selects the lowest-index
// pending source, which is offered to the CPU as a vector. On accept the
// IF bit is cleared and the matching int_ack bit pulses for one cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   a, din, wr, rd      CPU bus (rd is informational only)
//   dout                combinational read data (IF at 0xFF0F, IE at 0xFFFF)
//   int_req / int_ack   peripheral request inputs / one-cycle acks
//   ime                 CPU master interrupt enable
//   int_pending         any IF & IE bit set, regardless of ime
//   int_valid/int_vector/int_accept  dispatch handshake to the CPU
module interrupt_controller
  import gb_defs::*;
#(
  parameter int         NUM_INT       = 5,
  parameter logic [7:0] VECTOR_BASE   = gb_defs::VECTOR_BASE,
  parameter int         VECTOR_STRIDE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        a,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  input  logic               rd,
  input  logic               wr,
  input  logic [NUM_INT-1:0] int_req,
  output logic [NUM_INT-1:0] int_ack,
  input  logic               ime,
  output logic               int_pending,
  output logic               int_valid,
  output logic [7:0]         int_vector,
  input  logic               int_accept
);

  logic [NUM_INT-1:0] if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  logic [NUM_INT-1:0] req_prev_q, req_prev_d;
  int_state_e         state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         vector_q, vector_d;
  logic [NUM_INT-1:0] ack_q, ack_d;

  logic               wr_if, wr_ie;
  logic [NUM_INT-1:0] set_mask, clr_mask, qual;
  logic               sel_found;
  logic [2:0]         sel_idx;
  logic               unused_rd;

  assign unused_rd = rd;

  assign wr_if    = wr && (a == ADDR_IF);
  assign wr_ie    = wr && (a == ADDR_IE);
  assign set_mask = int_req & ~req_prev_q;
  assign qual     = if_q & ie_q[NUM_INT-1:0];

  int_prio_enc #(.N(NUM_INT)) u_prio_enc (
    .req   (qual),
    .found (sel_found),
    .idx   (sel_idx)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    vector_d   = vector_q;
    ack_d      = '0;
    clr_mask   = '0;
    req_prev_d = int_req;
    ie_d       = wr_ie ? din : ie_q;

    case (state_q)
      ST_IDLE: begin
        if (ime && sel_found) begin
          idx_d    = sel_idx;
          vector_d = VECTOR_BASE + 8'(int'(sel_idx) * VECTOR_STRIDE);
          state_d  = ST_OFFER;
        end
      end
      ST_OFFER: begin
        // idx/vector stay frozen here; re-arbitration only from IDLE.
        if (int_accept) begin
          clr_mask = NUM_INT'(1) << idx_q;
          ack_d    = NUM_INT'(1) << idx_q;
          state_d  = ST_IDLE;
        end else if (!(if_q[idx_q] && ie_q[idx_q]) || !ime) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Write first, then dispatch clear, then edge set wins over both.
    if_d = ((wr_if ? din[NUM_INT-1:0] : if_q) & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_q       <= '0;
      ie_q       <= '0;
      req_prev_q <= '0;
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      vector_q   <= VECTOR_BASE;
      ack_q      <= '0;
    end else begin
      if_q       <= if_d;
      ie_q       <= ie_d;
      req_prev_q <= req_prev_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      vector_q   <= vector_d;
      ack_q      <= ack_d;
    end
  end

  always_comb begin
    dout = 8'hFF;
    if (a == ADDR_IF)      dout = {{(8 - NUM_INT){1'b1}}, if_q};
    else if (a == ADDR_IE) dout = ie_q;
  end

  assign int_pending = |qual;
  assign int_valid   = (state_q == ST_OFFER);
  assign int_vector  = vector_q;
  assign int_ack     = ack_q;

endmodule

// File: tb/tb_interrupt_controller.sv
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rd;
  logic        wr;
  logic [4:0]  int_req;
  logic [4:0]  int_ack;
  logic        ime;
  logic        int_pending;
  logic        int_valid;
  logic [7:0]  int_vector;
  logic        int_accept;

  int checks = 0;
  int errors = 0;

  interrupt_controller dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .din         (din),
    .dout        (dout),
    .rd          (rd),
    .wr          (wr),
    .int_req     (int_req),
    .int_ack     (int_ack),
    .ime         (ime),
    .int_pending (int_pending),
    .int_valid   (int_valid),
    .int_vector  (int_vector),
    .int_accept  (int_accept)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    a = addr; din = data; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic test_reset();
    a = 16'hFF0F; #1;
    checks++; if (dout !== 8'hE0) begin errors++; $display("FAIL reset_if got %h exp %h", dout, 8'hE0); end
    a = 16'hFFFF; #1;
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_ie got %h exp %h", dout, 8'h00); end
    a = 16'h1234; #1;
    checks++; if (dout !== 8'hFF) begin errors++; $display("FAIL other_addr got %h exp %h", dout, 8'hFF); end
    checks++; if (int_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", int_valid); end
    checks++; if (int_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", int_pending); end
    checks++; if (int_vector !== 8'h40) begin errors++; $display("FAIL reset_vector got %h exp 40", int_vector); end
    checks++; if (int_ack !== 5'h00) begin errors++; $display("FAIL reset_ack got %h exp 00", int_ack); end
  endtask

  task automatic test_timer();
    bus_write(16'hFFFF, 8'h04);
    ime = 1'b1;
    int_req = 5'b00100;
    tick();
    a = 16'hFF0F; #1;
    checks++; if (dout !== 8'hE4) begin errors++; $display("FAIL tim_if_set got %h exp E4", dout); end
    checks++; if (int_pending !== 1'b1) begin errors++; $display("FAIL tim_pending got %b exp 1", int_pending); end
    checks++; if (int_valid !== 1'b0) begin errors++; $display("FAIL tim_valid_early got %b exp 0", int_valid); end
    tick();
    checks++; if (int_valid !== 1'b1) begin errors++; $display("FAIL tim_valid got %b exp 1", int_valid); end
    checks++; if (int_vector !== 8'h50) begin errors++; $display("FAIL tim_vector got %h exp 50", int_vector); end
    int_accept = 1'b1;
    tick();
    int_accept = 1'b0;
    checks++; if (int_ack !== 5'b00100) begin errors++; $display("FAIL tim_ack got %b exp 00100", int_ack); end
    checks++; if (int_valid !== 1'b0) begin errors++; $display("FAIL tim_valid_drop got %b exp 0", int_valid); end
    checks++; if (dout !== 8'hE0) begin errors++; $display("FAIL tim_if_clr got %h exp E0", dout); end
    tick();
    checks++; if (int_ack !== 5'b00000) begin errors++; $display("FAIL tim_ack_width got %b exp 00000", int_ack); end
    checks++; if (dout !== 8'hE0) begin errors++; $display("FAIL tim_held_level got %h exp E0", dout); end
    checks++; if (int_valid !== 1'b0) begin errors++; $display("FAIL tim_no_reoffer got %b exp 0", int_valid); end
    int_req = 5'b00000;
    tick();
  endtask

  task automatic test_priority();
    bus_write(16'hFFFF, 8'h1F);
    int_req = 5'b10001;
    tick();
    a = 16'hFF0F; #1;
    checks++; if (dout !== 8'hF1) begin errors++; $display("FAIL pri_if got %h exp F1", dout); end
    tick();
    checks++; if (int_valid !== 1'b1 || int_vector !== 8'h40) begin errors++; $display("FAIL pri_first got v=%b vec=%h exp v=1 vec=40", int_valid, int_vector); end
    int_accept = 1'b1;
    tick();
    int_accept = 1'b0;
    checks++; if (int_ack !== 5'b00001) begin errors++; $display("FAIL pri_ack0 got %b exp 00001", int_ack); end
    checks++; if (dout !== 8'hF0) begin errors++; $display("FAIL pri_if_mid got %h exp F0", dout); end
    checks++; if (int_valid !== 1'b0) begin errors++; $display("FAIL pri_idle_gap got %b exp 0", int_valid); end
    tick();
    checks++; if (int_valid !== 1'b1 || int_vector !== 8'h60) begin errors++; $display("FAIL pri_second got v=%b vec=%h exp v=1 vec=60", int_valid, int_vector); end
    int_accept = 1'b1;
    tick();
    int_accept = 1'b0;
    checks++; if (int_ack !== 5'b10000) begin errors++; $display("FAIL pri_ack4 got %b exp 10000", int_ack); end
    checks++; if (dout !== 8'hE0) begin errors++; $display("FAIL pri_if_end got %h exp E0", dout); end
    int_req = 5'b00000;
    tick();
  endtask

  task automatic test_ime_gate();
    ime = 1'b0;
    bus_write(16'hFFFF, 8'h02);
    bus_write(16'hFF0F, 8'h02);
    checks++; if (int_pending !== 1'b1) begin errors++; $display("FAIL ime_pending got %b exp 1", int_pending); end
    tick();
    checks++; if (int_valid !== 1'b0) begin errors++; $display("FAIL ime_blocked got %b exp 0", int_valid); end
    ime = 1'b1;
    tick();
    checks++; if (int_valid !== 1'b1 || int_vector !== 8'h48) begin errors++; $display("FAIL ime_offer got v=%b vec=%h exp v=1 vec=48", int_valid, int_vector); end
    int_accept = 1'b1;
    tick();
    int_accept = 1'b0;
    checks++; if (int_ack !== 5'b00010) begin errors++; $display("FAIL ime_ack got %b exp 00010", int_ack); end
    tick();
  endtask

  task automatic test_cancel();
    ime = 1'b1;
    bus_write(16'hFFFF, 8'h04);
    int_req = 5'b00100;
    tick();
    tick();
    checks++; if (int_valid !== 1'b1 || int_vector !== 8'h50) begin errors++; $display("FAIL can_offer got v=%b vec=%h exp v=1 vec=50", int_valid, int_vector); end
    bus_write(16'hFF0F, 8'h00);
    checks++; if (int_ack !== 5'b00000) begin errors++; $display("FAIL can_ack1 got %b exp 00000", int_ack); end
    tick();
    checks++; if (int_valid !== 1'b0) begin errors++; $display("FAIL can_valid got %b exp 0", int_valid); end
    checks++; if (int_ack !== 5'b00000) begin errors++; $display("FAIL can_ack2 got %b exp 00000", int_ack); end
    int_req = 5'b00000;
    ime = 1'b0;
    tick();
    int_req = 5'b01000;
    bus_write(16'hFF0F, 8'h00);
    a = 16'hFF0F; #1;
    checks++; if (dout !== 8'hE8) begin errors++; $display("FAIL edge_beats_write got %h exp E8", dout); end
    int_req = 5'b00000;
    bus_write(16'hFF0F, 8'h00);
  endtask

  task automatic test_accept_write_and_reset();
    ime = 1'b1;
    bus_write(16'hFFFF, 8'h04);
    bus_write(16'hFF0F, 8'h04);
    tick();
    checks++; if (int_valid !== 1'b1) begin errors++; $display("FAIL aw_offer got %b exp 1", int_valid); end
    int_accept = 1'b1;
    bus_write(16'hFF0F, 8'h1F);
    int_accept = 1'b0;
    a = 16'hFF0F; #1;
    checks++; if (dout !== 8'hFB) begin errors++; $display("FAIL aw_if got %h exp FB", dout); end
    checks++; if (int_ack !== 5'b00100) begin errors++; $display("FAIL aw_ack got %b exp 00100", int_ack); end
    tick();
    checks++; if (int_valid !== 1'b0) begin errors++; $display("FAIL aw_no_reoffer got %b exp 0", int_valid); end
    bus_write(16'hFF0F, 8'h04);
    tick();
    checks++; if (int_valid !== 1'b1) begin errors++; $display("FAIL rst_offer got %b exp 1", int_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a = 16'hFF0F; #1;
    checks++; if (int_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", int_valid); end
    checks++; if (int_ack !== 5'b00000) begin errors++; $display("FAIL rst_ack got %b exp 00000", int_ack); end
    checks++; if (dout !== 8'hE0) begin errors++; $display("FAIL rst_if got %h exp E0", dout); end
    checks++; if (int_vector !== 8'h40) begin errors++; $display("FAIL rst_vector got %h exp 40", int_vector); end
  endtask

  initial begin
    rst = 1'b1; a = 16'h0000; din = 8'h00; rd = 1'b0; wr = 1'b0;
    int_req = 5'b00000; ime = 1'b0; int_accept = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_timer();
    test_priority();
    test_ime_gate();
    test_cancel();
    test_accept_write_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
